apb_cmd_master: RTL and testbench
=================================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter TIMEOUT, default 16: the maximum number of ACCESS cycles with pready low before the transfer is aborted; 0 disables the timeout.
REQ-002 pclk  input  1  clock; all state updates on its rising edge.
REQ-003 preset  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-006 cmd_addr  input  14  bits [13:12] select the target (psel one-hot), bits [11:0] give paddr.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and for timeouts.
REQ-012 rsp_err  output  1  pslverr captured at completion, or 1 on timeout.
REQ-013 paddr  output  12; pwrite  output  1; psel  output  4; penable  output  1; pwdata  output  32  APB request signals.
REQ-014 prdata  input  32; pready  input  1; pslverr  input  1  APB completion signals.

Function
REQ-015 Every output shall be driven from a register; no output shall have a combinational path from any input.
REQ-016 The FSM states shall be IDLE, SETUP, ACCESS and RESP; the reset state shall be IDLE.
REQ-017 In IDLE, cmd_ready shall be 1; in every other state, cmd_ready shall be 0.
REQ-018 IDLE->SETUP: on an edge where cmd_valid=1 and cmd_ready=1, latch paddr=cmd_addr[11:0], pwrite=cmd_write, pwdata (cmd_wdata for writes, 0 for reads) and psel=1<<cmd_addr[13:12]; penable stays 0.
REQ-019 SETUP->ACCESS after exactly one cycle: penable=1, with psel, paddr, pwrite and pwdata held stable.
REQ-020 ACCESS: on an edge sampling pready=1, capture rsp_rdata=prdata (reads) or 0 (writes) and rsp_err=pslverr; then psel=0, penable=0, rsp_valid=1, go to RESP.
REQ-021 ACCESS: a wait counter counts consecutive cycles with pready=0. When TIMEOUT!=0 and the counter reaches TIMEOUT, abort: psel=0, penable=0, rsp_rdata=0, rsp_err=1, rsp_valid=1, go to RESP. The counter clears on entry to SETUP.
REQ-022 If pready=1 on the same edge that the timeout would fire, the pready completion takes priority.
REQ-023 RESP: hold rsp_valid, rsp_rdata and rsp_err until an edge where rsp_ready=1, then clear rsp_valid and go to IDLE.
REQ-024 A new command shall not be accepted on the RESP->IDLE edge; the minimum command-to-command spacing is 4 cycles.
REQ-025 Zero-wait latency: command handshake at edge 0 -> psel high from edge 0, penable high from edge 1, pready sampled at edge 2 -> rsp_valid high from edge 2.
REQ-026 psel shall be one-hot or zero at all times.
REQ-027 Outside SETUP and ACCESS, psel and penable shall be 0.
REQ-028 paddr, pwrite and pwdata shall retain their last values while the block is idle.
REQ-029 pslverr and prdata shall be ignored in every state other than ACCESS.

Reset
REQ-030 While preset=0, asynchronously force state=IDLE, cmd_ready=1, and psel, penable, paddr, pwrite, pwdata, rsp_valid, rsp_rdata, rsp_err and the wait counter to 0.
REQ-031 Reset asserted mid-transfer shall abort the transfer with no response; psel and penable shall drop in the same cycle that preset falls.
REQ-032 After preset rises, the block shall accept a command on the first clock edge with cmd_valid=1.

Verification
REQ-033 Write addr 0x2_0A4, data 0xDEADBEEF, pready=1 immediately -> psel=4'b0100, paddr=0x0A4, pwdata held for SETUP and ACCESS, rsp_valid at edge 2, rsp_err=0, rsp_rdata=0.
REQ-034 Read addr 0x3_FFC, pready low for 3 ACCESS cycles then high with prdata=0x12345678 and pslverr=1 -> psel=4'b1000, rsp_rdata=0x12345678, rsp_err=1.
REQ-035 TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles with rsp_err=1 and rsp_rdata=0, psel=0; pready=1 on exactly the 4th cycle -> normal completion instead.
REQ-036 rsp_ready held 0 for 10 cycles -> rsp_valid, rsp_rdata and rsp_err stable, cmd_ready=0, and a pending cmd_valid is not accepted.
REQ-037 preset pulsed low during ACCESS -> psel=0 and penable=0 immediately, rsp_valid=0, and the next command completes normally.
REQ-038 Back-to-back commands with cmd_valid and rsp_ready held 1 -> one transfer every 4 cycles, psel never multi-hot, penable never high without psel.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Bundle of the command/response handshake and the APB request/completion
// signals for apb_cmd_master. The master modport is the block's own view.
// The slave modport is the view of whatever drives commands and models the
// APB target.
interface apb_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [13:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [11:0] paddr;
    logic        pwrite;
    logic [3:0]  psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        input  rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        output rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwrite, psel, penable, pwdata
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB command master: takes one command at a time and runs it as a single APB
// transfer on one of four targets, chosen by cmd_addr[13:12].
// The result comes back on a valid/ready response channel.
// The transfer is aborted with an error if the target stalls for TIMEOUT
// consecutive ACCESS cycles. TIMEOUT = 0 turns the timeout off.
// Every output comes straight from a register.
module apb_cmd_master #(
    parameter int TIMEOUT = 16
) (
    input  logic             pclk,
    input  logic             preset,
    apb_cmd_master_if.master bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t        state_q;
    logic          cmd_ready_q;
    logic [11:0]   paddr_q;
    logic          pwrite_q;
    logic [3:0]    psel_q;
    logic          penable_q;
    logic [31:0]   pwdata_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic [CW-1:0] wait_q;
    logic [CW-1:0] wait_d;
    logic          timeout_hit;

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Stall counter: fires on the stalled cycle that brings the count up to
    // TIMEOUT, and otherwise counts one more stalled ACCESS cycle.
    always_comb begin
        wait_d      = wait_q;
        timeout_hit = 1'b0;
        if (state_q == ACCESS && !bus.pready && TIMEOUT != 0) begin
            if (wait_q == WAIT_LIMIT) begin
                timeout_hit = 1'b1;
            end else begin
                wait_d = wait_q + CW'(1);
            end
        end
    end

    // Transfer sequencer. It owns every registered output.
    // pready completion is checked before the timeout, so a target that
    // answers on the last allowed cycle still completes normally.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        paddr_q     <= bus.cmd_addr[11:0];
                        pwrite_q    <= bus.cmd_write;
                        pwdata_q    <= bus.cmd_write ? bus.cmd_wdata : 32'h0;
                        psel_q      <= 4'b0001 << bus.cmd_addr[13:12];
                        penable_q   <= 1'b0;
                        wait_q      <= '0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    wait_q <= wait_d;
                    if (bus.pready) begin
                        rsp_rdata_q <= pwrite_q ? 32'h0 : bus.prdata;
                        rsp_err_q   <= bus.pslverr;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master.
// The model only knows what each transfer should produce and how long it
// should take: timed out or not, response data and error, and
// handshake-to-response latency.
// Inputs are driven and outputs sampled on the falling edge.
module tb_apb_cmd_master;

    localparam int TO = 4;

    logic pclk = 1'b0;
    logic preset;
    int   nChecks = 0;
    int   nPass   = 0;

    apb_cmd_master_if ifc ();

    apb_cmd_master #(.TIMEOUT(TO)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (ifc)
    );

    // Free-running clock.
    always #5 pclk = ~pclk;

    // Hard stop in case some stimulus loop desynchronises from the DUT.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // One complete transfer from an idle DUT.
    // nWait is the number of ACCESS cycles the target stalls before pready.
    // hold is the number of cycles the response is back-pressured.
    task automatic applyStimulus(input logic [13:0] addr, input logic wr, input logic [31:0] wdata,
                                 input int nWait, input logic [31:0] rdata, input logic err,
                                 input int hold);
        logic [3:0]  expPsel;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
        logic        expErr;
        logic        timedOut;
        int          expLatency;
        int          k;

        timedOut   = (TO != 0) && (nWait >= TO);
        expPsel    = 4'b0001 << addr[13:12];
        expWdata   = wr ? wdata : 32'h0;
        expRdata   = (timedOut || wr) ? 32'h0 : rdata;
        expErr     = timedOut ? 1'b1 : err;
        expLatency = timedOut ? (TO + 1) : (nWait + 2);

        checkOutput("cmd_ready_idle", ifc.cmd_ready, 1);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_addr  = addr;
        ifc.cmd_write = wr;
        ifc.cmd_wdata = wdata;
        ifc.pready    = 1'b0;
        @(negedge pclk);
        ifc.cmd_valid = 1'b0;
        ifc.cmd_addr  = 14'($urandom);
        ifc.cmd_write = 1'($urandom);
        ifc.cmd_wdata = $urandom;

        k = 0;
        while (ifc.rsp_valid !== 1'b1 && k < 40) begin
            checkOutput("psel", ifc.psel, expPsel);
            checkOutput("penable", ifc.penable, (k >= 1));
            checkOutput("paddr", ifc.paddr, addr[11:0]);
            checkOutput("pwrite", ifc.pwrite, wr);
            checkOutput("pwdata", ifc.pwdata, expWdata);
            checkOutput("cmd_ready_busy", ifc.cmd_ready, 0);
            if (k >= 1 && (k - 1) == nWait) begin
                ifc.pready  = 1'b1;
                ifc.prdata  = rdata;
                ifc.pslverr = err;
            end else begin
                ifc.pready  = 1'b0;
                ifc.prdata  = $urandom;
                ifc.pslverr = 1'($urandom);
            end
            @(negedge pclk);
            k++;
        end
        ifc.pready  = 1'b0;
        ifc.prdata  = $urandom;
        ifc.pslverr = 1'($urandom);

        checkOutput("latency", k, expLatency);
        checkOutput("rsp_rdata", ifc.rsp_rdata, expRdata);
        checkOutput("rsp_err", ifc.rsp_err, expErr);
        checkOutput("psel_resp", ifc.psel, 0);
        checkOutput("penable_resp", ifc.penable, 0);
        checkOutput("cmd_ready_resp", ifc.cmd_ready, 0);

        ifc.cmd_valid = 1'b1;
        ifc.rsp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge pclk);
            checkOutput("rsp_valid_hold", ifc.rsp_valid, 1);
            checkOutput("rsp_rdata_hold", ifc.rsp_rdata, expRdata);
            checkOutput("rsp_err_hold", ifc.rsp_err, expErr);
            checkOutput("cmd_ready_hold", ifc.cmd_ready, 0);
            checkOutput("psel_hold", ifc.psel, 0);
        end

        ifc.rsp_ready = 1'b1;
        @(negedge pclk);
        ifc.rsp_ready = 1'b0;
        ifc.cmd_valid = 1'b0;
        checkOutput("rsp_valid_done", ifc.rsp_valid, 0);
        checkOutput("cmd_ready_back", ifc.cmd_ready, 1);
        checkOutput("psel_idle", ifc.psel, 0);
        checkOutput("paddr_retained", ifc.paddr, addr[11:0]);
        checkOutput("pwrite_retained", ifc.pwrite, wr);
        checkOutput("pwdata_retained", ifc.pwdata, expWdata);
    endtask

    // Directed and random sequence.
    initial begin
        int setups;
        int lastSetup;
        int spacingBad;
        int multiHot;
        int enNoSel;
        int rsps;

        preset        = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_addr  = '0;
        ifc.cmd_write = 1'b0;
        ifc.cmd_wdata = '0;
        ifc.rsp_ready = 1'b0;
        ifc.prdata    = '0;
        ifc.pready    = 1'b0;
        ifc.pslverr   = 1'b0;
        repeat (2) @(negedge pclk);

        $display("[TB] reset state");
        checkOutput("rst_cmd_ready", ifc.cmd_ready, 1);
        checkOutput("rst_psel", ifc.psel, 0);
        checkOutput("rst_penable", ifc.penable, 0);
        checkOutput("rst_paddr", ifc.paddr, 0);
        checkOutput("rst_pwrite", ifc.pwrite, 0);
        checkOutput("rst_pwdata", ifc.pwdata, 0);
        checkOutput("rst_rsp_valid", ifc.rsp_valid, 0);
        checkOutput("rst_rsp_rdata", ifc.rsp_rdata, 0);
        checkOutput("rst_rsp_err", ifc.rsp_err, 0);
        preset = 1'b1;

        $display("[TB] zero-wait write");
        applyStimulus(14'h20A4, 1'b1, 32'hDEADBEEF, 0, $urandom, 1'b0, 0);

        $display("[TB] read with three wait cycles and slave error");
        applyStimulus(14'h3FFC, 1'b0, 32'h0, 3, 32'h12345678, 1'b1, 1);

        $display("[TB] timeout with pready held low");
        applyStimulus(14'h1010, 1'b0, 32'h0, 100, 32'hCAFEF00D, 1'b0, 0);

        $display("[TB] pready on the last allowed access cycle");
        applyStimulus(14'h0004, 1'b0, 32'h0, TO - 1, 32'hA5A55A5A, 1'b0, 0);

        $display("[TB] long response back-pressure");
        applyStimulus(14'h2100, 1'b1, 32'h01234567, 1, 32'h0, 1'b1, 10);

        $display("[TB] random transfers");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(14'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, TO + 2)),
                          $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] reset during access");
        ifc.cmd_valid = 1'b1;
        ifc.cmd_addr  = 14'h3123;
        ifc.cmd_write = 1'b1;
        ifc.cmd_wdata = 32'h55AA55AA;
        ifc.pready    = 1'b0;
        @(negedge pclk);
        ifc.cmd_valid = 1'b0;
        @(negedge pclk);
        checkOutput("penable_before_reset", ifc.penable, 1);
        #2 preset = 1'b0;
        #1;
        checkOutput("psel_async_reset", ifc.psel, 0);
        checkOutput("penable_async_reset", ifc.penable, 0);
        checkOutput("rsp_valid_async_reset", ifc.rsp_valid, 0);
        checkOutput("cmd_ready_async_reset", ifc.cmd_ready, 1);
        checkOutput("paddr_async_reset", ifc.paddr, 0);
        @(negedge pclk);
        preset = 1'b1;
        applyStimulus(14'h1ABC, 1'b0, 32'h0, 2, 32'h0BADF00D, 1'b0, 0);

        $display("[TB] back-to-back commands");
        setups     = 0;
        lastSetup  = 0;
        spacingBad = 0;
        multiHot   = 0;
        enNoSel    = 0;
        rsps       = 0;
        ifc.cmd_valid = 1'b1;
        ifc.rsp_ready = 1'b1;
        ifc.pready    = 1'b1;
        ifc.pslverr   = 1'b0;
        for (int c = 0; c < 16; c++) begin
            ifc.cmd_addr  = 14'($urandom);
            ifc.cmd_write = 1'($urandom);
            ifc.cmd_wdata = $urandom;
            ifc.prdata    = $urandom;
            @(negedge pclk);
            if (ifc.psel != 4'b0000 && !ifc.penable) begin
                if (setups > 0 && (c - lastSetup) != 4) spacingBad++;
                setups++;
                lastSetup = c;
            end
            if (!$onehot0(ifc.psel)) multiHot++;
            if (ifc.penable && ifc.psel == 4'b0000) enNoSel++;
            if (ifc.rsp_valid) rsps++;
        end
        ifc.cmd_valid = 1'b0;
        ifc.rsp_ready = 1'b0;
        ifc.pready    = 1'b0;
        checkOutput("b2b_setups", setups, 4);
        checkOutput("b2b_spacing", spacingBad, 0);
        checkOutput("b2b_multihot", multiHot, 0);
        checkOutput("b2b_penable_no_psel", enNoSel, 0);
        checkOutput("b2b_responses", rsps, 4);
        checkOutput("b2b_cmd_ready_end", ifc.cmd_ready, 1);

        applyStimulus(14'h0FF0, 1'b1, 32'hFEEDFACE, 0, 32'h0, 1'b0, 2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
